// File: rtl/zap_fetch_main_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding and prefetch FIFO entry layout.
package zap_fetch_main_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam int ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] data;
        logic        abort;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/zap_fetch_main_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
interface zap_fetch_main_if;
    logic        o_instr_req;
    logic [31:0] o_instr_addr;
    logic        i_instr_ack;
    logic [31:0] i_instr_data;
    logic        i_instr_abort;

    modport master (
        output o_instr_req, o_instr_addr,
        input  i_instr_ack, i_instr_data, i_instr_abort
    );

    modport slave (
        input  o_instr_req, o_instr_addr,
        output i_instr_ack, i_instr_data, i_instr_abort
    );
endinterface

// File: rtl/zap_fetch_fifo.sv
// Prefetch FIFO: synchronous push/pop/flush; push while full is accepted only alongside a pop.
module zap_fetch_fifo
    import zap_fetch_main_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     din_i,
    input  logic             pop_i,
    output fetch_entry_t     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   free_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [PTR_W:0]     cnt_q;
    logic               do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign free_o  = (PTR_W+1)'(DEPTH) - cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = fetch_entry_t'(mem_q[rd_q]);

    always_ff @(posedge i_clk) begin
        if (i_reset || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q] <= ENTRY_W'(din_i);
    end

endmodule

// File: rtl/zap_fetch_main.sv
// Instruction fetch stage: single-outstanding word reads, prefetch FIFO, front-end clear/stall priority.
// Optional ZAP_FETCH_PERF_EN adds saturating fetched/discarded-word counters.
module zap_fetch_main
    import zap_fetch_main_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int PTR_W      = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic [31:0] i_pc_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic [31:0] i_pc_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_decode,
    input  logic [31:0] i_pc_from_decode,
    output logic [31:0] o_inst_ff,
    output logic        o_val_ff,
    output logic        o_abt_ff,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
`ifdef ZAP_FETCH_PERF_EN
    output logic [31:0] o_fetch_count,
    output logic [15:0] o_discard_count,
`endif
    zap_fetch_main_if.master instr_bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, addr_q, addr_d;
    logic         req_q, req_d;
    logic         clr, stall, load, take;
    logic [31:0]  clr_pc;
    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PTR_W:0] fifo_free, free_after;
    fetch_entry_t fifo_head, ack_word, out_word;

    always_comb begin
        clr    = 1'b0;
        stall  = 1'b0;
        clr_pc = '0;
        if (i_clear_from_writeback) begin
            clr    = 1'b1;
            clr_pc = i_pc_from_writeback;
        end else if (i_data_stall) begin
            stall = 1'b1;
        end else if (i_clear_from_alu) begin
            clr    = 1'b1;
            clr_pc = i_pc_from_alu;
        end else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) begin
            stall = 1'b1;
        end else if (i_clear_from_decode) begin
            clr    = 1'b1;
            clr_pc = i_pc_from_decode;
        end
    end

    // An empty FIFO lets the acked word fall straight through to the output regs.
    always_comb begin
        take       = (state_q == REQ) && instr_bus.i_instr_ack && !clr;
        load       = !clr && !stall;
        fifo_pop   = load && !fifo_empty;
        fifo_push  = take && !(load && fifo_empty);
        free_after = fifo_free + (PTR_W+1)'(fifo_pop) - (PTR_W+1)'(fifo_push);
        ack_word   = '{data: instr_bus.i_instr_data, abort: instr_bus.i_instr_abort, pc: addr_q};
        out_word   = fifo_empty ? ack_word : fifo_head;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (!clr && !fifo_full) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (instr_bus.i_instr_ack) begin
                    // A clear coinciding with the ack closes the transaction here; nothing left to discard.
                    if (clr) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        pc_d = pc_q + 32'd4;
                        if (free_after != '0) begin
                            addr_d = pc_q + 32'd4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end else if (clr) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (instr_bus.i_instr_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (clr) pc_d = word_align(clr_pc);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || clr) begin
            o_inst_ff      <= '0;
            o_val_ff       <= 1'b0;
            o_abt_ff       <= 1'b0;
            o_pc_ff        <= '0;
            o_pc_plus_8_ff <= 32'd8;
        end else if (load) begin
            if (!fifo_empty || take) begin
                o_inst_ff      <= out_word.data;
                o_val_ff       <= 1'b1;
                o_abt_ff       <= out_word.abort;
                o_pc_ff        <= out_word.pc;
                o_pc_plus_8_ff <= out_word.pc + 32'd8;
            end else begin
                o_val_ff <= 1'b0;
                o_abt_ff <= 1'b0;
            end
        end
    end

    assign instr_bus.o_instr_req  = req_q;
    assign instr_bus.o_instr_addr = addr_q;

    zap_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .flush_i (clr),
        .push_i  (fifo_push),
        .din_i   (ack_word),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .free_o  (fifo_free)
    );

`ifdef ZAP_FETCH_PERF_EN
    logic fetched, dropped;
    assign fetched = load && (!fifo_empty || take);
    assign dropped = instr_bus.i_instr_ack && ((state_q == DISCARD) || (state_q == REQ && clr));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fetch_count   <= '0;
            o_discard_count <= '0;
        end else begin
            if (fetched && o_fetch_count != '1)   o_fetch_count   <= o_fetch_count + 32'd1;
            if (dropped && o_discard_count != '1) o_discard_count <= o_discard_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/zap_fetch_main.md
Name: zap_fetch_main

Overview:
- Instruction fetch stage; sits directly upstream of the branch predictor stage and drives its i_inst/i_val/i_abt/i_pc_plus_8/i_pc inputs.
- Owns the fetch PC, issues single-outstanding word reads on the instruction bus, and buffers returned words in a small FIFO so bus acks are never lost while the pipeline stalls.
- Applies the same clear/stall priority as the rest of the front end, so a redirect kills all in-flight fetches.

Parameters:
FIFO_DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.
PTR_W, 1, FIFO pointer width, equal to log2(FIFO_DEPTH).

Ports:
i_clk  in  1  clock.
i_reset  in  1  synchronous active-high reset.
i_clear_from_writeback  in  1  redirect to i_pc_from_writeback.
i_pc_from_writeback  in  32  redirect target.
i_data_stall  in  1  global data stall.
i_clear_from_alu  in  1  redirect to i_pc_from_alu.
i_pc_from_alu  in  32  redirect target.
i_stall_from_shifter  in  1  downstream stall.
i_stall_from_issue  in  1  downstream stall.
i_stall_from_decode  in  1  downstream stall.
i_clear_from_decode  in  1  redirect to i_pc_from_decode.
i_pc_from_decode  in  32  redirect target.
o_instr_req  out  1  bus read request, held until ack.
o_instr_addr  out  32  word address, bits [1:0] = 0.
i_instr_ack  in  1  bus ack; data/abort valid this cycle.
i_instr_data  in  32  fetched word.
i_instr_abort  in  1  prefetch abort for this word.
o_inst_ff  out  32  instruction to predictor.
o_val_ff  out  1  instruction valid.
o_abt_ff  out  1  prefetch abort.
o_pc_ff  out  32  PC of the instruction.
o_pc_plus_8_ff  out  32  o_pc_ff + 8.

Behaviour:
- Reset: o_inst_ff = 0, o_val_ff = 0, o_abt_ff = 0, o_pc_ff = 0, o_pc_plus_8_ff = 8, o_instr_req = 0, o_instr_addr = 0, fetch PC = 0, FIFO empty, FSM = IDLE.
- Reset mid-transaction returns to IDLE immediately. A late ack after reset is ignored.
- Clear/stall priority per cycle (highest first):
  - reset
  - clear_from_writeback
  - data_stall
  - clear_from_alu
  - stall_from_shifter
  - stall_from_issue
  - stall_from_decode
  - clear_from_decode
  - normal
- Clear action: fetch PC <= target & ~3. Flush FIFO. Output regs take reset values. If FSM = REQ, go to DISCARD, else IDLE.
- Stall holds output registers. The FIFO still accepts acks.
- FSM states:
  - IDLE: if FIFO has free space (counting the pending word), assert o_instr_req with o_instr_addr = fetch PC, then go to REQ.
  - REQ: hold req/addr stable. On ack, push {data, abort, addr} and fetch PC += 4. Then go to REQ again if space remains, else IDLE (back-to-back: new address the cycle after ack).
  - DISCARD: keep req asserted with the old address until ack. Drop the returned word, deassert req, go to IDLE. A new request for the redirected PC is issued from IDLE the next cycle.
- Output load (normal case): if FIFO not empty, pop the head into the output regs and set o_val_ff = 1. Otherwise o_val_ff = 0; o_inst_ff and o_pc_ff are don't-care.
- o_pc_plus_8_ff = popped PC + 8, modulo 2^32.
- Push and pop in the same cycle are allowed when the FIFO is full: count stays unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Fetch PC wraps 0xFFFFFFFC -> 0x00000000.
- An abort word is delivered with o_abt_ff = 1 and o_inst_ff = data. Fetching continues.
- Latency: ack in cycle N with empty FIFO and no stall gives o_val_ff = 1 at N+1.

Optional Feature:
- Macro: ZAP_FETCH_PERF_EN.
- Defined: adds output o_fetch_count (32 bits), incremented on every popped valid instruction, and o_discard_count (16 bits), incremented on each dropped ack. Both reset to 0 and saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/header zap_fetch_defs.vh holds FSM state encodings (IDLE = 0, REQ = 1, DISCARD = 2) and the FIFO entry width (65 bits: data 32 + abort 1 + pc 32).
- One sub-module, zap_fetch_fifo: synchronous FIFO with push/pop/flush and full/empty/free-count outputs.

Test Plan:
- Reset, ack every cycle, no stall: o_val_ff = 1 from cycle 2. o_pc_ff = 0, 4, 8. o_pc_plus_8_ff = 8, 12, 16.
- Hold i_stall_from_decode for 4 cycles while acks continue: FIFO fills to 2 and req drops. Outputs hold, no word is lost, and order is preserved after release.
- Assert i_clear_from_alu with i_pc_from_alu = 0x103 while REQ is pending: FSM enters DISCARD and the next ack is dropped. Next o_instr_addr = 0x100 and first o_pc_ff = 0x100.
- i_clear_from_writeback (target 0x40) together with i_data_stall: writeback wins, outputs cleared, fetch PC = 0x40. i_data_stall together with i_clear_from_alu: stall wins.
- Ack with i_instr_abort = 1 at addr 0x20: o_abt_ff = 1, o_pc_ff = 0x20, next fetch 0x24.
- Fetch PC 0xFFFFFFFC acked: next o_instr_addr = 0x00000000 and o_pc_plus_8_ff = 0x00000004.
